pe_unary_mac: RTL

Parametrised unary-stream processing element for the systolic GEMM array. Each PE holds a sign-magnitude binary weight and rate-codes it on the fly against a forwarded random number. It multiplies the result bitwise with an incoming unary input stream and accumulates a signed count over one stream window. It then adds the partial sum arriving from its neighbour and emits it with a valid strobe. Weights are double-buffered, so a new weight can be shifted in while the current window computes.

---
 rtl/pe_unary_mac_if.sv | 62 ++++++
 rtl/pe_unary_mac.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pe_unary_mac_if.sv
// ---------------------------------------------------------------------------
// pe_unary_mac_if
// Bundles every non-clock signal of one unary-stream PE.
//   weight path   : w_load, w_abs_in, w_sign_in -> w_abs_out, w_sign_out
//   stream path   : in_valid, in_abs_bit, in_sign, in_rand, in_last
//                   -> registered copies *_o for the east neighbour
//   partial sums  : psum_in, psum_in_valid -> psum_out, psum_out_valid
//   status        : busy, proto_err
// The slave modport is the PE side. The master modport is the driver side
// (the west neighbour or a testbench).
// ---------------------------------------------------------------------------
interface pe_unary_mac_if #(
    parameter int BW_WEIGHT = 4,
    parameter int BW_RAND   = BW_WEIGHT - 1,
    parameter int BW_OUT    = 8
);
    logic                 w_load;
    logic [BW_WEIGHT-2:0] w_abs_in;
    logic                 w_sign_in;
    logic [BW_WEIGHT-2:0] w_abs_out;
    logic                 w_sign_out;

    logic                 in_valid;
    logic                 in_abs_bit;
    logic                 in_sign;
    logic [BW_RAND-1:0]   in_rand;
    logic                 in_last;

    logic                 in_valid_o;
    logic                 in_abs_bit_o;
    logic                 in_sign_o;
    logic [BW_RAND-1:0]   in_rand_o;
    logic                 in_last_o;

    logic [BW_OUT-1:0]    psum_in;
    logic                 psum_in_valid;
    logic [BW_OUT-1:0]    psum_out;
    logic                 psum_out_valid;

    logic                 busy;
    logic                 proto_err;

    modport slave (
        input  w_load, w_abs_in, w_sign_in,
        output w_abs_out, w_sign_out,
        input  in_valid, in_abs_bit, in_sign, in_rand, in_last,
        output in_valid_o, in_abs_bit_o, in_sign_o, in_rand_o, in_last_o,
        input  psum_in, psum_in_valid,
        output psum_out, psum_out_valid,
        output busy, proto_err
    );

    modport master (
        output w_load, w_abs_in, w_sign_in,
        input  w_abs_out, w_sign_out,
        output in_valid, in_abs_bit, in_sign, in_rand, in_last,
        input  in_valid_o, in_abs_bit_o, in_sign_o, in_rand_o, in_last_o,
        output psum_in, psum_in_valid,
        input  psum_out, psum_out_valid,
        input  busy, proto_err
    );
endinterface

// File: rtl/pe_unary_mac.sv
// ---------------------------------------------------------------------------
// pe_unary_mac
// Unary-stream processing element for the systolic GEMM array.
// The PE rate-codes a sign-magnitude weight against a forwarded random
// number, ANDs it with the incoming unary stream and accumulates a saturating
// signed count over one window. It then adds the neighbour partial sum and
// emits the total with a one-cycle strobe.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high reset
//   pe    - pe_unary_mac_if.slave carrying the weight, stream, psum and
//           status signals
// ---------------------------------------------------------------------------
module pe_unary_mac #(
    parameter int BW_WEIGHT = 4,
    parameter int BW_RAND   = BW_WEIGHT - 1,
    parameter int BW_OUT    = 8
) (
    input  logic          clk,
    input  logic          reset,
    pe_unary_mac_if.slave pe
);
    localparam int BW_ABS = BW_WEIGHT - 1;
    localparam int BW_CMP = (BW_ABS > BW_RAND) ? BW_ABS : BW_RAND;
    localparam logic signed [BW_OUT-1:0] ACC_MAX = {1'b0, {(BW_OUT-1){1'b1}}};
    localparam logic signed [BW_OUT-1:0] ACC_MIN = {1'b1, {(BW_OUT-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT_PSUM} state_t;

    // Two's-complement add that clamps to the BW_OUT range. The sum is
    // formed one bit wider, so overflow shows up as the top two bits differing.
    function automatic logic signed [BW_OUT-1:0] sat_add(
        input logic signed [BW_OUT-1:0] a,
        input logic signed [BW_OUT-1:0] b
    );
        logic [BW_OUT:0] s;
        s = {a[BW_OUT-1], a} + {b[BW_OUT-1], b};
        if (s[BW_OUT] != s[BW_OUT-1]) begin
            return s[BW_OUT] ? ACC_MIN : ACC_MAX;
        end
        return s[BW_OUT-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic [BW_ABS-1:0]        shadow_abs_q, act_abs_q, act_abs_d;
    logic                     shadow_sign_q, act_sign_q, act_sign_d;
    logic signed [BW_OUT-1:0] acc_q, acc_d, psum_out_q, psum_out_d;
    logic                     psum_out_valid_q, psum_out_valid_d;
    logic                     busy_q, proto_err_q, proto_err_d;
    logic                     fwd_valid_q, fwd_abs_bit_q, fwd_sign_q, fwd_last_q;
    logic [BW_RAND-1:0]       fwd_rand_q;

    logic [BW_ABS-1:0]        w_eff_abs;
    logic                     w_eff_sign, wbit, pbit, psign, last_bit;
    logic signed [BW_OUT-1:0] step, acc_base, acc_sum, acc_final, psum_sum;

    // The first bit of a window is seen in IDLE. It must already use the
    // weight that is being latched from the shadow register in that cycle.
    assign w_eff_abs  = (state_q == S_IDLE) ? shadow_abs_q  : act_abs_q;
    assign w_eff_sign = (state_q == S_IDLE) ? shadow_sign_q : act_sign_q;

    assign wbit     = BW_CMP'(w_eff_abs) > BW_CMP'(pe.in_rand);
    assign pbit     = wbit & pe.in_abs_bit;
    assign psign    = w_eff_sign ^ pe.in_sign;
    assign last_bit = pe.in_valid & pe.in_last;

    assign step      = !(pe.in_valid & pbit) ? '0
                     : (psign ? {BW_OUT{1'b1}} : BW_OUT'(1));
    assign acc_base  = (state_q == S_IDLE) ? '0 : acc_q;
    assign acc_sum   = sat_add(acc_base, step);
    // In WAIT_PSUM the window is closed. Stray input bits there must not
    // leak into the result.
    assign acc_final = (state_q == S_WAIT_PSUM) ? acc_q : acc_sum;
    assign psum_sum  = sat_add(acc_final, $signed(pe.psum_in));

    always_comb begin
        state_d          = state_q;
        acc_d            = acc_q;
        act_abs_d        = act_abs_q;
        act_sign_d       = act_sign_q;
        psum_out_d       = psum_out_q;
        psum_out_valid_d = 1'b0;
        proto_err_d      = proto_err_q;
        case (state_q)
            S_IDLE, S_ACC: begin
                if (pe.in_valid) begin
                    acc_d   = acc_sum;
                    state_d = pe.in_last ? S_WAIT_PSUM : S_ACC;
                    if (state_q == S_IDLE) begin
                        act_abs_d  = shadow_abs_q;
                        act_sign_d = shadow_sign_q;
                    end
                end
                // A partial sum that arrives together with the last bit closes
                // the window at once. At any other time it is a protocol error.
                if (pe.psum_in_valid) begin
                    if (last_bit) begin
                        psum_out_d       = psum_sum;
                        psum_out_valid_d = 1'b1;
                        state_d          = S_IDLE;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
            end
            S_WAIT_PSUM: begin
                if (pe.in_valid) begin
                    proto_err_d = 1'b1;
                end
                if (pe.psum_in_valid) begin
                    psum_out_d       = psum_sum;
                    psum_out_valid_d = 1'b1;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            shadow_abs_q     <= '0;
            shadow_sign_q    <= 1'b0;
            act_abs_q        <= '0;
            act_sign_q       <= 1'b0;
            acc_q            <= '0;
            psum_out_q       <= '0;
            psum_out_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            proto_err_q      <= 1'b0;
            fwd_valid_q      <= 1'b0;
            fwd_abs_bit_q    <= 1'b0;
            fwd_sign_q       <= 1'b0;
            fwd_rand_q       <= '0;
            fwd_last_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            if (pe.w_load) begin
                shadow_abs_q  <= pe.w_abs_in;
                shadow_sign_q <= pe.w_sign_in;
            end
            act_abs_q        <= act_abs_d;
            act_sign_q       <= act_sign_d;
            acc_q            <= acc_d;
            psum_out_q       <= psum_out_d;
            psum_out_valid_q <= psum_out_valid_d;
            busy_q           <= (state_d != S_IDLE);
            proto_err_q      <= proto_err_d;
            fwd_valid_q      <= pe.in_valid;
            fwd_abs_bit_q    <= pe.in_abs_bit;
            fwd_sign_q       <= pe.in_sign;
            fwd_rand_q       <= pe.in_rand;
            fwd_last_q       <= pe.in_last;
        end
    end

    assign pe.w_abs_out      = shadow_abs_q;
    assign pe.w_sign_out     = shadow_sign_q;
    assign pe.in_valid_o     = fwd_valid_q;
    assign pe.in_abs_bit_o   = fwd_abs_bit_q;
    assign pe.in_sign_o      = fwd_sign_q;
    assign pe.in_rand_o      = fwd_rand_q;
    assign pe.in_last_o      = fwd_last_q;
    assign pe.psum_out       = psum_out_q;
    assign pe.psum_out_valid = psum_out_valid_q;
    assign pe.busy           = busy_q;
    assign pe.proto_err      = proto_err_q;
endmodule
